// File: rtl/phase_seq.sv
// phase_seq: parametrised one-hot phase sequencer for the multicycle CPU
// control path. Steps through NPHASE phase strobes per instruction, with
// stall hold, early retire, halt/resume, single-step and a retired count.
//
// Ports:
//   clk        clock, rising edge
//   n_rst      asynchronous active-low reset
//   hlt        halt request (level), forces phases off
//   run        resume pulse, leaves HALTED
//   stall      hold current phase
//   last       current phase is the final one of this instruction
//   step_mode  1 = advance only when step is high
//   step       single-step advance enable
//   phase      one-hot phase vector, zero when not running (registered)
//   running    high while in RUN (registered)
//   inst_cnt   retired-instruction count, wraps (registered)
module phase_seq #(
  parameter int unsigned NPHASE   = 5,
  parameter int unsigned RST_SYNC = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              hlt,
  input  logic              run,
  input  logic              stall,
  input  logic              last,
  input  logic              step_mode,
  input  logic              step,
  output logic [NPHASE-1:0] phase,
  output logic              running,
  output logic [CNT_W-1:0]  inst_cnt
);

  localparam int unsigned PH_W = NPHASE;
  localparam int unsigned SY_W = RST_SYNC;
  localparam int unsigned CN_W = CNT_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [CN_W-1:0]   cnt_q, cnt_d;
  logic              running_q, running_d;
  logic [SY_W-1:0]   sync_q;
  logic              sync_done;

  // Start-up synchroniser: ones shift in after reset release.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SY_W-2:0], 1'b1};
    end
  end

  assign sync_done = sync_q[SY_W-1];

  // State and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
    end
  end

  // Next-state, next-phase and retire-count logic.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (hlt) begin
          state_d = HALTED;
        end else if (sync_done) begin
          phase_d = PH_W'(1);
          state_d = RUN;
        end
      end

      RUN: begin
        if (hlt) begin
          // In-flight instruction is abandoned without being counted.
          phase_d = '0;
          state_d = HALTED;
        end else if (stall) begin
          phase_d = phase_q;
        end else if (step_mode && !step) begin
          phase_d = phase_q;
        end else if (last || phase_q[PH_W-1]) begin
          // Retire: last in the final phase still counts only once.
          phase_d = PH_W'(1);
          cnt_d   = cnt_q + CN_W'(1);
        end else begin
          phase_d = {phase_q[PH_W-2:0], phase_q[PH_W-1]};
        end
      end

      HALTED: begin
        phase_d = '0;
        if (run && !hlt) begin
          phase_d = PH_W'(1);
          state_d = RUN;
        end
      end

      default: begin
        phase_d = '0;
        state_d = IDLE;
      end
    endcase

    running_d = (state_d == RUN);
  end

  assign phase    = phase_q;
  assign running  = running_q;
  assign inst_cnt = cnt_q;

endmodule
